seed_unpack: RTL

Front-end of the key-generation seed path. Consumes the 1024-bit SHAKE256 squeeze output of H(ξ‖k‖l) as a stream of 64-bit words and splits it into ρ (256 b), ρ′ (512 b) and K (256 b). Each field is handed to the seed data memory with a one-cycle write-enable pulse as soon as that field is complete, so matrix expansion can start before ρ′ and K arrive.

---
 rtl/seed_unpack_pkg.sv | 22 ++
 rtl/seed_unpack.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seed_unpack_pkg.sv
// Shared constants and state type for the seed unpacker: field sizes, word
// indices at which each field completes, and the two-state FSM encoding.
package seed_unpack_pkg;

  localparam int WORD_W          = 64;
  localparam int NUM_WORDS       = 16;
  localparam int RHO_WORDS       = 4;
  localparam int RHO_PRIME_WORDS = 8;
  localparam int KATA_WORDS      = 4;

  // Word indices are typed to the 4-bit counter so compares stay width-matched.
  localparam logic [3:0] RHO_LAST       = 4'(RHO_WORDS - 1);
  localparam logic [3:0] RHO_PRIME_LAST = 4'(RHO_WORDS + RHO_PRIME_WORDS - 1);
  localparam logic [3:0] KATA_LAST      = 4'(NUM_WORDS - 1);
  localparam logic [3:0] RHO_PRIME_BASE = 4'(RHO_WORDS);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/seed_unpack.sv
// Splits the 16-word SHAKE256 seed block into rho, rho' and K, pulsing each
// field's write enable as soon as it is complete. Framing check: SEED_UNPACK_LAST_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for start, no words accepted
// COLLECT | accepting squeeze words into the field buffers
module seed_unpack
  import seed_unpack_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WORD_W-1:0]                    in_data,
  input  logic                                 in_last,
  output logic                                 rho_en,
  output logic [RHO_WORDS*WORD_W-1:0]          rho_din,
  output logic                                 rho_prime_en,
  output logic [RHO_PRIME_WORDS*WORD_W-1:0]    rho_prime_din,
  output logic                                 kata_en,
  output logic [KATA_WORDS*WORD_W-1:0]         kata_din,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic [3:0] rp_idx;
  logic       accept;
  logic       abort;
  logic       begin_unpack;

  assign accept       = in_valid & in_ready;
  assign begin_unpack = (state == IDLE) & start;
  assign rp_idx       = cnt - RHO_PRIME_BASE;

`ifdef SEED_UNPACK_LAST_CHECK_EN
  // An early in_last truncates the block; the final word without it only flags.
  assign abort = accept & in_last & (cnt != KATA_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (begin_unpack) begin
      err <= 1'b0;
    end else if (abort || (accept && cnt == KATA_LAST && !in_last)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_in_last;

  assign unused_in_last = in_last;
  assign abort          = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && (cnt == KATA_LAST || abort)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state == COLLECT) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // Buffers only take words for their own slot range, so a completed field
  // holds its value until the next start clears it.
  always_ff @(posedge clk) begin
    if (reset || begin_unpack) begin
      cnt           <= '0;
      rho_din       <= '0;
      rho_prime_din <= '0;
      kata_din      <= '0;
    end else if (accept) begin
      cnt <= cnt + 4'd1;
      if (cnt <= RHO_LAST) begin
        rho_din[cnt[1:0]*WORD_W +: WORD_W] <= in_data;
      end else if (cnt <= RHO_PRIME_LAST) begin
        rho_prime_din[rp_idx[2:0]*WORD_W +: WORD_W] <= in_data;
      end else begin
        kata_din[cnt[1:0]*WORD_W +: WORD_W] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rho_en       <= 1'b0;
      rho_prime_en <= 1'b0;
      kata_en      <= 1'b0;
    end else begin
      rho_en       <= accept & ~abort & (cnt == RHO_LAST);
      rho_prime_en <= accept & ~abort & (cnt == RHO_PRIME_LAST);
      kata_en      <= accept & (cnt == KATA_LAST);
    end
  end

  assign done = kata_en;

endmodule
